rtc_bus_read_seq: RTL and testbench

- Sequencer that performs one read cycle on the RTC's multiplexed address/data bus (Intel-style: CS#, A/D#, RD#, WR#, shared 8-bit AD lines).
- Drives the register address onto the shared lines, then releases them to high-Z. It then strobes RD# and captures the byte the RTC returns.
- It is the read-side counterpart of the bus write/drive path in the RTC controller. Its ad_out/ad_oe feed the existing tri-state bus driver; ad_in comes from the pad.

---
 rtl/rtc_bus_read_seq.sv | 121 ++++++++++++
 tb/tb_rtc_bus_read_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_read_seq.sv
// One read cycle on the RTC's multiplexed AD bus: address phase, turnaround,
// RD# strobe with a single capture at its end, then CS# recovery.
module rtc_bus_read_seq #(
  parameter int unsigned T_ADDR = 4,
  parameter int unsigned T_RD   = 6,
  parameter int unsigned T_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    TURN = 3'd2,
    READ = 3'd3,
    HOLD = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] ADDR_LOAD = 8'(T_ADDR - 1);
  localparam logic [7:0] RD_LOAD   = 8'(T_RD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(T_GAP - 1);

  state_t     state;
  logic [7:0] count;

  assign wr_n = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      cs_n     <= 1'b1;
      ad_n     <= 1'b1;
      rd_n     <= 1'b1;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE shares the accept path so a held start chains reads without an idle cycle
        IDLE, DONE: begin
          if (start) begin
            state  <= ADDR;
            count  <= ADDR_LOAD;
            ad_out <= addr;
            ad_oe  <= 1'b1;
            cs_n   <= 1'b0;
            ad_n   <= 1'b0;
            rd_n   <= 1'b1;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ADDR: begin
          if (count == '0) begin
            state  <= TURN;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            ad_n   <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        TURN: begin
          state <= READ;
          count <= RD_LOAD;
          rd_n  <= 1'b0;
        end
        READ: begin
          if (count == '0) begin
            state    <= HOLD;
            count    <= GAP_LOAD;
            data_out <= ad_in;
            rd_n     <= 1'b1;
            cs_n     <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        HOLD: begin
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          count  <= '0;
          ad_out <= '0;
          ad_oe  <= 1'b0;
          cs_n   <= 1'b1;
          ad_n   <= 1'b1;
          rd_n   <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_read_seq.sv
// Directed bench for rtc_bus_read_seq at default timing (4/6/2).
module tb_rtc_bus_read_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] addr;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int done_at = -1;

  // {cs_n, ad_n, rd_n, ad_oe, busy, done}
  localparam logic [5:0] C_IDLE = 6'b111000;
  localparam logic [5:0] C_ADDR = 6'b001110;
  localparam logic [5:0] C_TURN = 6'b011010;
  localparam logic [5:0] C_READ = 6'b010010;
  localparam logic [5:0] C_HOLD = 6'b111010;
  localparam logic [5:0] C_DONE = 6'b111011;

  rtc_bus_read_seq #(.T_ADDR(4), .T_RD(6), .T_GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n),
    .wr_n(wr_n), .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [5:0] exp_ctl(input int k);
    if (k < 4)       return C_ADDR;
    else if (k == 4) return C_TURN;
    else if (k < 11) return C_READ;
    else if (k < 13) return C_HOLD;
    else             return C_DONE;
  endfunction

  function automatic logic [7:0] ctl;
    return {2'b00, cs_n, ad_n, rd_n, ad_oe, busy, done};
  endfunction

  task automatic accept(input logic [7:0] a);
    start = 1'b1;
    addr  = a;
    tick();
  endtask

  // Walks cycles k=0..13 after the accepting edge, ending just after edge 14.
  task automatic follow(input logic [7:0] a, input logic [7:0] d_early,
                        input logic [7:0] d_final, input logic [7:0] prev,
                        input bit keep_start, input logic [7:0] next_addr,
                        input bit poke);
    for (int k = 0; k < 14; k++) begin
      if (k == 0) begin
        if (!keep_start) start = 1'b0;
        addr = next_addr;
      end
      if (poke && k == 7) begin
        start = 1'b1;
        addr  = 8'h99;
      end
      if (poke && k == 8) start = 1'b0;
      ad_in = (k == 10) ? d_final : d_early;
      check("ctl", ctl(), {2'b00, exp_ctl(k)});
      if (k < 4) check("ad_out", ad_out, a);
      check("data_out", data_out, (k >= 11) ? d_final : prev);
      check("oe_vs_rd", {7'd0, ad_oe & ~rd_n}, 8'd0);
      check("wr_n", {7'd0, wr_n}, 8'd1);
      if (done) done_at = cyc;
      tick();
    end
    if (!keep_start) check("idle_after", ctl(), {2'b00, C_IDLE});
  endtask

  initial begin
    int first_done;
    reset = 1'b0;
    start = 1'b1;
    addr  = 8'hA5;
    ad_in = 8'h00;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ctl", ctl(), {2'b00, C_IDLE});
      check("rst_ad_out", ad_out, 8'h00);
      check("rst_data", data_out, 8'h00);
      check("rst_wr_n", {7'd0, wr_n}, 8'd1);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_ctl", ctl(), {2'b00, C_IDLE});

    // single read, defaults; done must appear 13 edges after accept
    accept(8'h0E);
    first_done = cyc;
    follow(8'h0E, 8'h37, 8'h37, 8'h00, 1'b0, 8'h0E, 1'b0);
    check("latency", 8'(done_at - first_done), 8'd13);

    // late data: only the final READ sample counts; addr change after accept ignored
    accept(8'h2C);
    follow(8'h2C, 8'hFF, 8'h42, 8'h37, 1'b0, 8'h77, 1'b0);

    // start pulsed mid-READ with addr=0x99 is dropped
    accept(8'h05);
    follow(8'h05, 8'h11, 8'h6D, 8'h42, 1'b0, 8'h05, 1'b1);
    tick();
    check("no_queue", ctl(), {2'b00, C_IDLE});
    accept(8'h99);
    follow(8'h99, 8'h00, 8'hC3, 8'h6D, 1'b0, 8'h99, 1'b0);

    // start held high: back-to-back reads, done pulses 14 edges apart
    accept(8'h10);
    follow(8'h10, 8'h01, 8'hA1, 8'hC3, 1'b1, 8'h11, 1'b0);
    first_done = done_at;
    follow(8'h11, 8'h02, 8'hB2, 8'hA1, 1'b0, 8'h11, 1'b0);
    check("b2b_spacing", 8'(done_at - first_done), 8'd14);

    // reset in the 3rd READ cycle (k=7) aborts with no done
    accept(8'h21);
    for (int k = 0; k < 7; k++) begin
      start = 1'b0;
      ad_in = 8'hEE;
      tick();
    end
    check("pre_abort_ctl", ctl(), {2'b00, C_READ});
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_ctl", ctl(), {2'b00, C_IDLE});
    check("abort_data", data_out, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("abort_quiet", ctl(), {2'b00, C_IDLE});
    end
    accept(8'h0B);
    follow(8'h0B, 8'h5C, 8'h5C, 8'h00, 1'b0, 8'h0B, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
